// File: rtl/mp_sched_if.sv
// Bundle of the scheduler's layer-config, postprocessor, maxpool and buffer-write signals.
// master = environment side, slave = mp_sched.
interface mp_sched_if #(
    parameter int W_SIZE    = 16,
    parameter int W_CHANNEL = 16,
    parameter int OFM_DW    = 32,
    parameter int OFM_AW    = 17
) ();
    logic                 i_start;
    logic                 i_pool_en;
    logic [W_SIZE-1:0]    q_width;
    logic [W_SIZE-1:0]    q_height;
    logic [W_CHANNEL-1:0] q_channel_out;
    logic                 pp_vld;
    logic [OFM_DW-1:0]    pp_data;
    logic                 mp_in_vld;
    logic [OFM_DW-1:0]    mp_in_data;
    logic [W_SIZE-1:0]    mp_row;
    logic [W_SIZE-1:0]    mp_col;
    logic [W_CHANNEL-1:0] mp_chn;
    logic                 mp_out_vld;
    logic [OFM_DW-1:0]    mp_out_data;
    logic [OFM_AW-1:0]    mp_out_addr;
    logic                 o_wr_vld;
    logic [OFM_DW-1:0]    o_wr_data;
    logic [OFM_AW-1:0]    o_wr_addr;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;

    modport master (
        output i_start, i_pool_en, q_width, q_height, q_channel_out,
        output pp_vld, pp_data, mp_out_vld, mp_out_data, mp_out_addr,
        input  mp_in_vld, mp_in_data, mp_row, mp_col, mp_chn,
        input  o_wr_vld, o_wr_data, o_wr_addr, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_pool_en, q_width, q_height, q_channel_out,
        input  pp_vld, pp_data, mp_out_vld, mp_out_data, mp_out_addr,
        output mp_in_vld, mp_in_data, mp_row, mp_col, mp_chn,
        output o_wr_vld, o_wr_data, o_wr_addr, o_busy, o_done, o_err
    );
endinterface

// File: rtl/mp_sched.sv
// Per-layer scheduler: walks the postprocessor stream (tile, row, col), routes it to maxpool
// or straight to the buffer manager, and signals completion once every expected write lands.
module mp_sched #(
    parameter int W_SIZE    = 16,
    parameter int W_CHANNEL = 16,
    parameter int OFM_DW    = 32,
    parameter int OFM_AW    = 17,
    parameter int W_CNT     = 32
) (
    input  logic          clk,
    input  logic          rstn,
    mp_sched_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [W_SIZE-1:0]    W_ONE = {{(W_SIZE-1){1'b0}}, 1'b1};
    localparam logic [W_CHANNEL-1:0] C_ONE = {{(W_CHANNEL-1){1'b0}}, 1'b1};
    localparam logic [OFM_AW-1:0]    A_ONE = {{(OFM_AW-1){1'b0}}, 1'b1};
    localparam logic [W_CNT-1:0]     N_ONE = {{(W_CNT-1){1'b0}}, 1'b1};

    state_t               state_r;
    logic [W_SIZE-1:0]    w_r;
    logic [W_SIZE-1:0]    h_r;
    logic [W_CHANNEL-1:0] c_r;
    logic                 pool_r;
    logic [W_CNT-1:0]     exp_cnt_r;
    logic [W_CNT-1:0]     wr_cnt_r;
    logic [W_SIZE-1:0]    col_r;
    logic [W_SIZE-1:0]    row_r;
    logic [W_CHANNEL-1:0] chn_r;
    logic [OFM_AW-1:0]    addr_r;

    logic                 mp_in_vld_r;
    logic [OFM_DW-1:0]    mp_in_data_r;
    logic [W_SIZE-1:0]    mp_row_r;
    logic [W_SIZE-1:0]    mp_col_r;
    logic [W_CHANNEL-1:0] mp_chn_r;
    logic                 wr_vld_r;
    logic [OFM_DW-1:0]    wr_data_r;
    logic [OFM_AW-1:0]    wr_addr_r;
    logic                 done_r;
    logic                 err_r;

    logic                 cfg_bad_s;
    logic [W_CNT-1:0]     ew_s;
    logic [W_CNT-1:0]     eh_s;
    logic [W_CNT-1:0]     ec_s;
    logic [W_CNT-1:0]     exp_cnt_s;
    logic                 col_last_s;
    logic                 row_last_s;
    logic                 chn_last_s;
    logic                 pp_run_s;
    logic                 wr_req_s;
    logic                 wr_room_s;
    logic                 err_set_s;
    logic [OFM_AW-1:0]    c_step_s;

    // Pooling halves both spatial dimensions, so it needs even W and H.
    assign cfg_bad_s = (bus.q_width == '0) || (bus.q_height == '0) || (bus.q_channel_out == '0) ||
                       (bus.i_pool_en && (bus.q_width[0] || bus.q_height[0]));

    assign ew_s      = bus.i_pool_en ? W_CNT'(bus.q_width[W_SIZE-1:1])  : W_CNT'(bus.q_width);
    assign eh_s      = bus.i_pool_en ? W_CNT'(bus.q_height[W_SIZE-1:1]) : W_CNT'(bus.q_height);
    assign ec_s      = W_CNT'(bus.q_channel_out);
    assign exp_cnt_s = ew_s * eh_s * ec_s;

    assign col_last_s = (col_r == (w_r - W_ONE));
    assign row_last_s = (row_r == (h_r - W_ONE));
    assign chn_last_s = (chn_r == (c_r - C_ONE));
    assign c_step_s   = OFM_AW'(c_r);

    assign pp_run_s  = bus.pp_vld && (state_r == ST_RUN);
    assign wr_req_s  = pool_r ? (bus.mp_out_vld && (state_r != ST_IDLE)) : pp_run_s;
    assign wr_room_s = (wr_cnt_r < exp_cnt_r);

    // Dropped traffic: stray pp data, maxpool results with no pooled layer, or surplus writes.
    assign err_set_s = (bus.pp_vld && (state_r != ST_RUN)) ||
                       (bus.mp_out_vld && (!pool_r || (state_r == ST_IDLE))) ||
                       (wr_req_s && !wr_room_s);

    // Layer FSM, stream counters and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            w_r          <= '0;
            h_r          <= '0;
            c_r          <= '0;
            pool_r       <= 1'b0;
            exp_cnt_r    <= '0;
            wr_cnt_r     <= '0;
            col_r        <= '0;
            row_r        <= '0;
            chn_r        <= '0;
            addr_r       <= '0;
            mp_in_vld_r  <= 1'b0;
            mp_in_data_r <= '0;
            mp_row_r     <= '0;
            mp_col_r     <= '0;
            mp_chn_r     <= '0;
            wr_vld_r     <= 1'b0;
            wr_data_r    <= '0;
            wr_addr_r    <= '0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            mp_in_vld_r <= 1'b0;
            wr_vld_r    <= 1'b0;
            done_r      <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (cfg_bad_s) begin
                            err_r <= 1'b1;
                        end else begin
                            w_r       <= bus.q_width;
                            h_r       <= bus.q_height;
                            c_r       <= bus.q_channel_out;
                            pool_r    <= bus.i_pool_en;
                            exp_cnt_r <= exp_cnt_s;
                            wr_cnt_r  <= '0;
                            col_r     <= '0;
                            row_r     <= '0;
                            chn_r     <= '0;
                            addr_r    <= '0;
                            err_r     <= 1'b0;
                            state_r   <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pp_run_s && col_last_s && row_last_s && chn_last_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Compares the registered count, so DRAIN always lasts at least one cycle.
                    if (wr_cnt_r == exp_cnt_r) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            if (pp_run_s) begin
                if (pool_r) begin
                    mp_in_vld_r  <= 1'b1;
                    mp_in_data_r <= bus.pp_data;
                    mp_row_r     <= row_r;
                    mp_col_r     <= col_r;
                    mp_chn_r     <= chn_r;
                end
                // Address steps by C per pixel; each new tile restarts at its own channel index.
                if (col_last_s) begin
                    col_r <= '0;
                    if (row_last_s) begin
                        row_r  <= '0;
                        chn_r  <= chn_last_s ? '0 : (chn_r + C_ONE);
                        addr_r <= OFM_AW'(chn_r) + A_ONE;
                    end else begin
                        row_r  <= row_r + W_ONE;
                        addr_r <= addr_r + c_step_s;
                    end
                end else begin
                    col_r  <= col_r + W_ONE;
                    addr_r <= addr_r + c_step_s;
                end
            end

            if (wr_req_s && wr_room_s) begin
                wr_vld_r  <= 1'b1;
                wr_data_r <= pool_r ? bus.mp_out_data : bus.pp_data;
                wr_addr_r <= pool_r ? bus.mp_out_addr : addr_r;
                wr_cnt_r  <= wr_cnt_r + N_ONE;
            end

            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.mp_in_vld  = mp_in_vld_r;
    assign bus.mp_in_data = mp_in_data_r;
    assign bus.mp_row     = mp_row_r;
    assign bus.mp_col     = mp_col_r;
    assign bus.mp_chn     = mp_chn_r;
    assign bus.o_wr_vld   = wr_vld_r;
    assign bus.o_wr_data  = wr_data_r;
    assign bus.o_wr_addr  = wr_addr_r;
    assign bus.o_busy     = (state_r != ST_IDLE);
    assign bus.o_done     = done_r;
    assign bus.o_err      = err_r;
endmodule

// File: doc/mp_sched.md
MP_SCHED -- requirements
Module: mp_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- W_SIZE, 16, width/height field width
- W_CHANNEL, 16, channel-tile field width
- OFM_DW, 32, feature-map word width (4 ch x 8b)
- OFM_AW, 17, buffer address width
- W_CNT, 32, output counter width
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock
- rstn, in, 1, reset, asynchronous, active-low
- i_start, in, 1, layer start pulse
- i_pool_en, in, 1, 1 = route through maxpool, 0 = bypass
- q_width, in, W_SIZE, layer width
- q_height, in, W_SIZE, layer height
- q_channel_out, in, W_CHANNEL, number of output-channel tiles
- pp_vld, in, 1, postprocessor data valid
- pp_data, in, OFM_DW, postprocessor data
- mp_in_vld, out, 1, maxpool data valid
- mp_in_data, out, OFM_DW, maxpool data
- mp_row, out, W_SIZE, row of mp_in_data
- mp_col, out, W_SIZE, column of mp_in_data
- mp_chn, out, W_CHANNEL, channel tile of mp_in_data
- mp_out_vld, in, 1, maxpool result valid
- mp_out_data, in, OFM_DW, maxpool result
- mp_out_addr, in, OFM_AW, maxpool result address
- o_wr_vld, out, 1, buffer-manager write strobe
- o_wr_data, out, OFM_DW, write data
- o_wr_addr, out, OFM_AW, write address
- o_busy, out, 1, state != IDLE
- o_done, out, 1, one-cycle completion pulse
- o_err, out, 1, sticky error flag

Function
REQ-003 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-004 In IDLE, i_start SHALL latch q_width (W), q_height (H), q_channel_out (C) and i_pool_en, clear the counters, clear o_err, and go to RUN.
- Exception: on a configuration error the block SHALL set o_err and stay in IDLE.
- Configuration error: W=0, H=0 or C=0; or pool_en=1 with W or H odd.
REQ-005 i_start outside IDLE SHALL be ignored with no effect on state, counters or o_err.
REQ-006 The input stream order SHALL be: chn tile outermost, then row, then col innermost.
- Counters col/row/chn SHALL advance on each pp_vld in RUN.
- col wraps at W-1 and increments row; row wraps at H-1 and increments chn.
REQ-007 The pp_vld carrying col=W-1, row=H-1, chn=C-1 SHALL move RUN to DRAIN on the next cycle.
REQ-008 With pool_en=1, each pp_vld in RUN SHALL produce, one cycle later (registered), mp_in_vld=1, mp_in_data=pp_data, and mp_row/mp_col/mp_chn equal to the pre-increment counters.
- mp_in_vld SHALL be 0 otherwise.
REQ-009 With pool_en=1, each mp_out_vld SHALL produce, one cycle later, o_wr_vld=1 with o_wr_data=mp_out_data and o_wr_addr=mp_out_addr.
REQ-010 With pool_en=0, each pp_vld in RUN SHALL produce, one cycle later, o_wr_vld=1 and o_wr_data=pp_data; mp_in_vld SHALL stay 0.
- o_wr_addr = chn + pix*C, where pix = row*W + col.
- Address SHALL be generated incrementally: base=chn at each tile start, +C per pixel, no multiplier.
- Address SHALL be truncated to OFM_AW.
REQ-011 An expected-write count SHALL be computed at start: (W/2)*(H/2)*C if pool_en=1, else W*H*C, in W_CNT bits.
- Each o_wr_vld SHALL increment the write counter.
REQ-012 DRAIN SHALL go to DONE on the cycle the write counter reaches the expected count.
- DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
- If the final write lands in the same cycle as the RUN-to-DRAIN transition, DRAIN SHALL still be entered for one cycle before DONE.
REQ-013 The following SHALL be dropped and SHALL set o_err; state is unaffected:
- pp_vld in IDLE, DRAIN or DONE;
- mp_out_vld while pool_en=0 or in IDLE;
- a write that would exceed the expected count.
REQ-014 o_busy SHALL equal (state != IDLE), combinationally from the state register.

Reset
REQ-015 On rstn low, within the same cycle (asynchronously), the block SHALL:
- go to state IDLE;
- clear all counters and latched config;
- drive all outputs (mp_in_vld, mp_in_data, mp_row, mp_col, mp_chn, o_wr_vld, o_wr_data, o_wr_addr, o_busy, o_done, o_err) to 0.
REQ-016 Reset asserted mid-RUN or mid-DRAIN SHALL abort the layer with no o_done.
- After release, the block SHALL accept a new i_start normally.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Bypass: W=4, H=4, C=2, pool_en=0, 32 back-to-back pp_vld -> 32 writes; tile-0 addresses 0,2,4..30; tile-1 addresses 1,3..31; o_done exactly 1 cycle after the 32nd write.
- Pool: W=4, H=4, C=2, pool_en=1, with a maxpool model -> mp_row/mp_col/mp_chn sequence correct; 8 writes forwarded unchanged 1 cycle after mp_out_vld; o_done after the 8th write.
- Config error: start with W=3, pool_en=1 -> o_err=1, o_busy stays 0, no writes; a following valid start clears o_err.
- Protocol: i_start during RUN ignored; pp_vld during IDLE -> o_err=1, no write; gapped pp_vld (1 of 3 cycles) -> same addresses as back-to-back.
- Reset mid-RUN after 10 inputs -> all outputs 0 immediately, no o_done; a new W=2, H=2, C=1 bypass layer completes with addresses 0,1,2,3.
